// File: rtl/jmp_pkg.sv
// jmp_pkg
// Shared definitions for the jump/branch resolve slice:
//   - funct3 encodings for JAL/JALR and the six conditional branches
//   - control part of a branch-queue entry (valid, type, prediction)
//   - helpers classifying jump codes and evaluating branch outcome
// No ports (package).
package jmp_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_JAL  = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b011;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Width of a register index (rd / rs fields).
  localparam int REG_IDX_W = 5;

  // Control fields of one queued conditional branch. The address fields
  // (target, fall-through) depend on XLEN and live in the queue itself.
  typedef struct packed {
    logic       valid;
    logic [2:0] br_type;
    logic       pred;
  } br_ctrl_t;

  // True for the two unconditional jump encodings.
  function automatic logic is_jump_code(input logic [2:0] f3);
    return (f3 == F3_JAL) || (f3 == F3_JALR);
  endfunction

  // Branch outcome from the ALU flags. alu_lt already carries the signed
  // or unsigned comparison matching the branch type. Jump codes never
  // reach the queue as valid entries, so they evaluate as not taken.
  function automatic logic br_taken(input logic [2:0] f3,
                                    input logic       zero,
                                    input logic       lt);
    logic taken_v;
    case (f3)
      F3_BEQ:  taken_v = zero;
      F3_BNE:  taken_v = ~zero;
      F3_BLT:  taken_v = lt;
      F3_BLTU: taken_v = lt;
      F3_BGE:  taken_v = ~lt;
      F3_BGEU: taken_v = ~lt;
      default: taken_v = 1'b0;
    endcase
    return taken_v;
  endfunction

endpackage

// File: rtl/branch_queue.sv
// branch_queue
// Shift register carrying decoded conditional branches from decode to the
// cycle in which their ALU flags are valid. Entry 0 is written from decode
// every clock; entries move one step toward index DEPTH-1 each clock; only
// entry DEPTH-1 (the oldest) is presented for resolution.
// Ports:
//   clock, reset      clock and synchronous active-high reset
//   flush             clear every valid bit on this clock (mispredict)
//   enq_ctrl/tgt/ft   decode-stage entry (valid already qualified)
//   old_ctrl/tgt/ft   oldest entry, evaluated by the top level
//   any_valid         at least one queued entry is valid
module branch_queue
  import jmp_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  br_ctrl_t        enq_ctrl,
  input  logic [XLEN-1:0] enq_tgt,
  input  logic [XLEN-1:0] enq_ft,
  output br_ctrl_t        old_ctrl,
  output logic [XLEN-1:0] old_tgt,
  output logic [XLEN-1:0] old_ft,
  output logic            any_valid
);

  br_ctrl_t        ctrl_r [DEPTH];
  logic [XLEN-1:0] tgt_r  [DEPTH];
  logic [XLEN-1:0] ft_r   [DEPTH];
  logic            any_valid_s;

  // Queue storage: load entry 0, shift the rest, drop all valids on flush.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_r[i] <= '{valid: 1'b0, br_type: 3'b000, pred: 1'b0};
        tgt_r[i]  <= {XLEN{1'b0}};
        ft_r[i]   <= {XLEN{1'b0}};
      end
    end else begin
      ctrl_r[0] <= enq_ctrl;
      tgt_r[0]  <= enq_tgt;
      ft_r[0]   <= enq_ft;
      for (int i = 1; i < DEPTH; i++) begin
        ctrl_r[i] <= ctrl_r[i-1];
        tgt_r[i]  <= tgt_r[i-1];
        ft_r[i]   <= ft_r[i-1];
      end
      // A mispredict squashes everything younger than the resolving
      // branch; the resolving branch itself leaves the queue anyway.
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) begin
          ctrl_r[i].valid <= 1'b0;
        end
      end
    end
  end

  // OR-reduce the valid bits for the jump hazard check.
  always_comb begin
    any_valid_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      any_valid_s = any_valid_s | ctrl_r[i].valid;
    end
  end

  assign old_ctrl  = ctrl_r[DEPTH-1];
  assign old_tgt   = tgt_r[DEPTH-1];
  assign old_ft    = ft_r[DEPTH-1];
  assign any_valid = any_valid_s;

endmodule

// File: rtl/jump_resolve_unit.sv
// jump_resolve_unit
// Resolves JAL/JALR in decode and conditional branches RESOLVE_DEPTH cycles
// later when the ALU flags arrive. Optional static prediction redirects
// backward branches at decode; a wrong guess (in either direction) is
// repaired at resolve time and younger queued branches are squashed.
// Ports:
//   clock, reset                 clock, synchronous active-high reset
//   stall_in                     decode entry is enqueued as a bubble
//   new_jmp, jmp_type, jal_rs    decode jump/branch info (funct3, JALR rs1)
//   bus_j, imm, pc               jump base, signed offset, decode PC
//   prev_rd                      in-flight rd indices, entry 0 youngest
//   alu_zero, alu_lt             ALU flags for the oldest queued branch
//   new_pc, ctrl_fetch           combinational fetch redirect
//   flush_branch, flush_jal      registered: a redirect happened last cycle
//   halt                         combinational stall request
//   branch_cnt, mispredict_cnt   saturating statistics
module jump_resolve_unit
  import jmp_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int RESOLVE_DEPTH = 2,
  parameter int HAZ_DEPTH     = 2,
  parameter int PC_OFFSET     = 8,
  parameter bit PREDICT       = 1'b0,
  parameter int CNT_W         = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           stall_in,
  input  logic                           new_jmp,
  input  logic [2:0]                     jmp_type,
  input  logic [REG_IDX_W-1:0]           jal_rs,
  input  logic [XLEN-1:0]                bus_j,
  input  logic [XLEN-1:0]                imm,
  input  logic [XLEN-1:0]                pc,
  input  logic [REG_IDX_W*HAZ_DEPTH-1:0] prev_rd,
  input  logic                           alu_zero,
  input  logic                           alu_lt,
  output logic [XLEN-1:0]                new_pc,
  output logic                           ctrl_fetch,
  output logic                           flush_branch,
  output logic                           flush_jal,
  output logic                           halt,
  output logic [CNT_W-1:0]               branch_cnt,
  output logic [CNT_W-1:0]               mispredict_cnt
);

  localparam logic [XLEN-1:0]  PC_OFF_V    = XLEN'(PC_OFFSET);
  localparam logic [XLEN-1:0]  INSN_STEP_V = XLEN'(32'd4);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1'b1);

  // Decode-side signals
  logic            jal_dec_s;
  logic            is_br_s;
  logic [XLEN-1:0] pc_base_s;
  logic [XLEN-1:0] br_tgt_s;
  logic [XLEN-1:0] br_ft_s;
  logic [XLEN-1:0] jal_tgt_s;
  logic            pred_s;
  br_ctrl_t        enq_ctrl_s;

  // Resolve-side signals
  br_ctrl_t        old_ctrl_s;
  logic [XLEN-1:0] old_tgt_s;
  logic [XLEN-1:0] old_ft_s;
  logic            any_valid_s;
  logic            taken_s;
  logic            mispredict_s;
  logic            resolve_redirect_s;

  // Hazard and redirect selection
  logic            rd_hit_s;
  logic            halt_s;
  logic            jal_redirect_s;
  logic            pred_redirect_s;
  logic            ctrl_fetch_s;
  logic [XLEN-1:0] new_pc_s;

  // Registered state
  logic             flush_branch_r;
  logic             flush_jal_r;
  logic [CNT_W-1:0] branch_cnt_r;
  logic [CNT_W-1:0] mispredict_cnt_r;

  // ---------------------------------------------------------------------
  // Decode: classify and compute the candidate addresses. The decode PC
  // runs PC_OFFSET ahead of the instruction, so both the branch target
  // and the fall-through are rebased onto the instruction address.
  // ---------------------------------------------------------------------
  assign jal_dec_s = new_jmp & is_jump_code(jmp_type);
  assign is_br_s   = new_jmp & ~jal_dec_s;
  assign pc_base_s = pc - PC_OFF_V;
  assign br_tgt_s  = imm + pc_base_s;
  assign br_ft_s   = pc_base_s + INSN_STEP_V;
  assign jal_tgt_s = imm + bus_j;

  // Static backward-taken: a negative offset is guessed taken.
  assign pred_s = PREDICT & imm[XLEN-1];

  // The decode branch is dropped when stalled or when an older branch
  // is redirecting fetch this very cycle.
  assign enq_ctrl_s = '{valid:   is_br_s & ~stall_in & ~resolve_redirect_s,
                        br_type: jmp_type,
                        pred:    pred_s};

  branch_queue #(
    .DEPTH (RESOLVE_DEPTH),
    .XLEN  (XLEN)
  ) u_branch_queue (
    .clock     (clock),
    .reset     (reset),
    .flush     (resolve_redirect_s),
    .enq_ctrl  (enq_ctrl_s),
    .enq_tgt   (br_tgt_s),
    .enq_ft    (br_ft_s),
    .old_ctrl  (old_ctrl_s),
    .old_tgt   (old_tgt_s),
    .old_ft    (old_ft_s),
    .any_valid (any_valid_s)
  );

  // ---------------------------------------------------------------------
  // Resolve: only the oldest entry sees valid ALU flags.
  // ---------------------------------------------------------------------
  assign taken_s            = br_taken(old_ctrl_s.br_type, alu_zero, alu_lt);
  assign mispredict_s       = old_ctrl_s.valid & (taken_s != old_ctrl_s.pred);
  assign resolve_redirect_s = mispredict_s;

  // JALR source register matched against every in-flight destination.
  always_comb begin
    rd_hit_s = 1'b0;
    for (int i = 0; i < HAZ_DEPTH; i++) begin
      if (prev_rd[i*REG_IDX_W +: REG_IDX_W] == jal_rs) begin
        rd_hit_s = 1'b1;
      end else begin
        rd_hit_s = rd_hit_s;
      end
    end
  end

  // A jump waits while any unresolved branch could still redirect ahead
  // of it, or while its JALR base register is still being produced
  // (x0 is hard-wired and never a hazard).
  assign halt_s = jal_dec_s &
                  (any_valid_s |
                   ((jmp_type == F3_JALR) & (jal_rs != 5'd0) & rd_hit_s));

  assign jal_redirect_s  = jal_dec_s & ~halt_s & ~resolve_redirect_s;
  assign pred_redirect_s = is_br_s & pred_s & ~stall_in & ~resolve_redirect_s;

  // Redirect priority: resolve > jump > predicted-taken > none.
  always_comb begin
    ctrl_fetch_s = 1'b0;
    new_pc_s     = {XLEN{1'b0}};
    if (resolve_redirect_s) begin
      ctrl_fetch_s = 1'b1;
      new_pc_s     = taken_s ? old_tgt_s : old_ft_s;
    end else if (jal_redirect_s) begin
      ctrl_fetch_s = 1'b1;
      new_pc_s     = jal_tgt_s;
    end else if (pred_redirect_s) begin
      ctrl_fetch_s = 1'b1;
      new_pc_s     = br_tgt_s;
    end else begin
      ctrl_fetch_s = 1'b0;
      new_pc_s     = {XLEN{1'b0}};
    end
  end

  // Flush flags tell the downstream stages a redirect happened last cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      flush_branch_r <= 1'b0;
      flush_jal_r    <= 1'b0;
    end else begin
      flush_branch_r <= resolve_redirect_s | pred_redirect_s;
      flush_jal_r    <= jal_redirect_s;
    end
  end

  // Saturating branch and mispredict statistics.
  always_ff @(posedge clock) begin
    if (reset) begin
      branch_cnt_r     <= {CNT_W{1'b0}};
      mispredict_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (old_ctrl_s.valid && (branch_cnt_r != CNT_MAX)) begin
        branch_cnt_r <= branch_cnt_r + CNT_ONE;
      end
      if (mispredict_s && (mispredict_cnt_r != CNT_MAX)) begin
        mispredict_cnt_r <= mispredict_cnt_r + CNT_ONE;
      end
    end
  end

  assign new_pc         = new_pc_s;
  assign ctrl_fetch     = ctrl_fetch_s;
  assign halt           = halt_s;
  assign flush_branch   = flush_branch_r;
  assign flush_jal      = flush_jal_r;
  assign branch_cnt     = branch_cnt_r;
  assign mispredict_cnt = mispredict_cnt_r;

endmodule

// File: tb/tb_jump_resolve_unit.sv
// Directed bench for jump_resolve_unit. Two instances share one set of
// inputs: u_a (depth 2, backward-taken prediction, 4-bit counters so
// saturation is reachable) and u_b (depth 3, no prediction).
module tb_jump_resolve_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall_in;
  logic        new_jmp;
  logic [2:0]  jmp_type;
  logic [4:0]  jal_rs;
  logic [31:0] bus_j;
  logic [31:0] imm;
  logic [31:0] pc;
  logic [9:0]  prev_rd;
  logic        alu_zero;
  logic        alu_lt;

  logic [31:0] a_new_pc, b_new_pc;
  logic        a_ctrl_fetch, b_ctrl_fetch;
  logic        a_flush_branch, b_flush_branch;
  logic        a_flush_jal, b_flush_jal;
  logic        a_halt, b_halt;
  logic [3:0]  a_branch_cnt, a_mispredict_cnt;
  logic [15:0] b_branch_cnt, b_mispredict_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  jump_resolve_unit #(
    .XLEN(32), .RESOLVE_DEPTH(2), .HAZ_DEPTH(2), .PC_OFFSET(8),
    .PREDICT(1'b1), .CNT_W(4)
  ) u_a (
    .clock(clock), .reset(reset), .stall_in(stall_in), .new_jmp(new_jmp),
    .jmp_type(jmp_type), .jal_rs(jal_rs), .bus_j(bus_j), .imm(imm), .pc(pc),
    .prev_rd(prev_rd), .alu_zero(alu_zero), .alu_lt(alu_lt),
    .new_pc(a_new_pc), .ctrl_fetch(a_ctrl_fetch), .flush_branch(a_flush_branch),
    .flush_jal(a_flush_jal), .halt(a_halt), .branch_cnt(a_branch_cnt),
    .mispredict_cnt(a_mispredict_cnt)
  );

  jump_resolve_unit #(
    .XLEN(32), .RESOLVE_DEPTH(3), .HAZ_DEPTH(2), .PC_OFFSET(8),
    .PREDICT(1'b0), .CNT_W(16)
  ) u_b (
    .clock(clock), .reset(reset), .stall_in(stall_in), .new_jmp(new_jmp),
    .jmp_type(jmp_type), .jal_rs(jal_rs), .bus_j(bus_j), .imm(imm), .pc(pc),
    .prev_rd(prev_rd), .alu_zero(alu_zero), .alu_lt(alu_lt),
    .new_pc(b_new_pc), .ctrl_fetch(b_ctrl_fetch), .flush_branch(b_flush_branch),
    .flush_jal(b_flush_jal), .halt(b_halt), .branch_cnt(b_branch_cnt),
    .mispredict_cnt(b_mispredict_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    stall_in = 1'b0; new_jmp = 1'b0; jmp_type = 3'b000; jal_rs = 5'd0;
    bus_j = 32'h0; imm = 32'h0; pc = 32'h0; prev_rd = 10'h0;
    alu_zero = 1'b0; alu_lt = 1'b0;
  endtask

  task automatic drive_br(input logic [2:0] t, input logic [31:0] p,
                          input logic [31:0] i);
    drive_idle();
    new_jmp = 1'b1; jmp_type = t; pc = p; imm = i;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Branch in decode, one idle cycle, resolve with the given flags (u_a).
  task automatic run_branch(input logic [2:0] t, input logic [31:0] p,
                            input logic [31:0] i, input logic z, input logic l,
                            output logic cf, output logic [31:0] npc,
                            output logic fb);
    drive_br(t, p, i);
    tick();
    drive_idle();
    tick();
    drive_idle(); alu_zero = z; alu_lt = l;
    #1;
    cf = a_ctrl_fetch; npc = a_new_pc;
    tick();
    drive_idle();
    #1;
    fb = a_flush_branch;
  endtask

  typedef struct {
    logic [2:0]  t;
    logic [31:0] p;
    logic [31:0] i;
    logic        z;
    logic        l;
    logic        cf;
    logic [31:0] npc;
  } vec_t;

  vec_t vecs [6] = '{
    '{3'b000, 32'h108, 32'h20,  1'b1, 1'b0, 1'b1, 32'h120},
    '{3'b001, 32'h108, 32'h20,  1'b1, 1'b0, 1'b0, 32'h0},
    '{3'b110, 32'h500, 32'h100, 1'b0, 1'b1, 1'b1, 32'h5F8},
    '{3'b101, 32'h600, 32'h40,  1'b0, 1'b1, 1'b0, 32'h0},
    '{3'b111, 32'h700, 32'h10,  1'b0, 1'b0, 1'b1, 32'h708},
    '{3'b100, 32'h800, 32'h8,   1'b0, 1'b0, 1'b0, 32'h0}
  };

  logic        cf;
  logic [31:0] npc;
  logic        fb;

  initial begin
    reset = 1'b1;
    drive_idle();

    // Reset state
    do_reset();
    #1;
    check_eq("rst_branch_cnt", a_branch_cnt, 4'h0);
    check_eq("rst_misp_cnt", a_mispredict_cnt, 4'h0);
    check_eq("rst_flush_branch", a_flush_branch, 1'b0);
    check_eq("rst_flush_jal", a_flush_jal, 1'b0);
    check_eq("rst_ctrl_fetch", a_ctrl_fetch, 1'b0);
    check_eq("rst_new_pc", a_new_pc, 32'h0);
    check_eq("rst_halt", a_halt, 1'b0);
    check_eq("rst_b_branch_cnt", b_branch_cnt, 16'h0);

    // Forward branches (predicted not taken) resolved by type and flags
    drive_br(3'b000, 32'h108, 32'h20);
    #1;
    check_eq("fwd_no_pred_redirect", a_ctrl_fetch, 1'b0);
    tick();
    drive_idle();
    tick();
    drive_idle(); alu_zero = 1'b1;
    #1;
    check_eq("beq_resolve_fetch", a_ctrl_fetch, 1'b1);
    check_eq("beq_resolve_pc", a_new_pc, 32'h120);
    tick();
    drive_idle();
    #1;
    check_eq("beq_flush_branch", a_flush_branch, 1'b1);
    check_eq("beq_misp_cnt", a_mispredict_cnt, 4'h1);
    check_eq("beq_branch_cnt", a_branch_cnt, 4'h1);
    check_eq("beq_flush_jal", a_flush_jal, 1'b0);

    do_reset();
    for (int k = 0; k < 6; k++) begin
      run_branch(vecs[k].t, vecs[k].p, vecs[k].i, vecs[k].z, vecs[k].l, cf, npc, fb);
      check_eq($sformatf("vec%0d_fetch", k), cf, vecs[k].cf);
      check_eq($sformatf("vec%0d_pc", k), npc, vecs[k].npc);
      check_eq($sformatf("vec%0d_flush", k), fb, vecs[k].cf);
    end
    check_eq("vec_branch_cnt", a_branch_cnt, 4'd6);
    check_eq("vec_misp_cnt", a_mispredict_cnt, 4'd3);

    // Backward BNE predicted taken, then resolved not taken
    do_reset();
    drive_br(3'b001, 32'h208, 32'hFFFF_FFF0);
    #1;
    check_eq("pred_fetch", a_ctrl_fetch, 1'b1);
    check_eq("pred_pc", a_new_pc, 32'h1F0);
    tick();
    drive_idle();
    #1;
    check_eq("pred_flush_branch", a_flush_branch, 1'b1);
    tick();
    drive_idle(); alu_zero = 1'b1;
    #1;
    check_eq("pred_recover_fetch", a_ctrl_fetch, 1'b1);
    check_eq("pred_recover_pc", a_new_pc, 32'h204);
    tick();
    drive_idle();
    #1;
    check_eq("pred_misp_cnt", a_mispredict_cnt, 4'h1);
    check_eq("pred_recover_flush", a_flush_branch, 1'b1);
    // Backward BEQ predicted taken and actually taken: no recovery
    drive_br(3'b000, 32'h300, 32'hFFFF_FFE0);
    #1;
    check_eq("pred2_pc", a_new_pc, 32'h2D8);
    run_branch(3'b000, 32'h300, 32'hFFFF_FFE0, 1'b1, 1'b0, cf, npc, fb);
    check_eq("pred_ok_fetch", cf, 1'b0);
    check_eq("pred_ok_misp_cnt", a_mispredict_cnt, 4'h1);
    check_eq("pred_ok_branch_cnt", a_branch_cnt, 4'h2);

    // JALR hazard against prev_rd entry 1, then clearing
    do_reset();
    drive_idle();
    new_jmp = 1'b1; jmp_type = 3'b011; jal_rs = 5'd5;
    prev_rd = {5'd5, 5'd0}; bus_j = 32'h400; imm = 32'h4;
    #1;
    check_eq("jalr_haz_halt", a_halt, 1'b1);
    check_eq("jalr_haz_fetch", a_ctrl_fetch, 1'b0);
    tick();
    #1;
    check_eq("jalr_haz_flush_jal", a_flush_jal, 1'b0);
    prev_rd = 10'h0;
    #1;
    check_eq("jalr_go_halt", a_halt, 1'b0);
    check_eq("jalr_go_fetch", a_ctrl_fetch, 1'b1);
    check_eq("jalr_go_pc", a_new_pc, 32'h404);
    tick();
    drive_idle();
    #1;
    check_eq("jalr_flush_jal", a_flush_jal, 1'b1);
    check_eq("jalr_flush_branch", a_flush_branch, 1'b0);
    // x0 base never hazards; youngest entry does
    new_jmp = 1'b1; jmp_type = 3'b011; jal_rs = 5'd0;
    bus_j = 32'h1000; imm = 32'hFFFF_FF00;
    #1;
    check_eq("jalr_x0_halt", a_halt, 1'b0);
    check_eq("jalr_x0_pc", a_new_pc, 32'hF00);
    jal_rs = 5'd7; prev_rd = {5'd0, 5'd7};
    #1;
    check_eq("jalr_e0_halt", a_halt, 1'b1);
    tick();
    // JAL waits for queued branches
    drive_br(3'b000, 32'h108, 32'h20);
    tick();
    drive_idle(); new_jmp = 1'b1; jmp_type = 3'b010; bus_j = 32'h1000;
    #1;
    check_eq("jal_queue_halt", a_halt, 1'b1);
    check_eq("jal_queue_fetch", a_ctrl_fetch, 1'b0);
    tick();
    tick();
    #1;
    check_eq("jal_free_halt", a_halt, 1'b0);
    check_eq("jal_free_pc", a_new_pc, 32'h1000);
    tick();

    // Depth 3: first of two taken branches squashes the second
    do_reset();
    drive_br(3'b000, 32'h108, 32'h20);
    tick();
    drive_br(3'b000, 32'h10C, 32'h40);
    tick();
    drive_idle();
    tick();
    alu_zero = 1'b1;
    #1;
    check_eq("d3_first_fetch", b_ctrl_fetch, 1'b1);
    check_eq("d3_first_pc", b_new_pc, 32'h120);
    tick();
    #1;
    check_eq("d3_second_squashed", b_ctrl_fetch, 1'b0);
    tick();
    #1;
    check_eq("d3_branch_cnt", b_branch_cnt, 16'd1);
    check_eq("d3_misp_cnt", b_mispredict_cnt, 16'd1);

    // Resolve redirect beats a JAL in decode
    do_reset();
    drive_br(3'b000, 32'h108, 32'h20);
    tick();
    drive_idle();
    tick();
    drive_idle(); new_jmp = 1'b1; jmp_type = 3'b010; bus_j = 32'h300;
    imm = 32'h10; alu_zero = 1'b1;
    #1;
    check_eq("prio_fetch", a_ctrl_fetch, 1'b1);
    check_eq("prio_pc", a_new_pc, 32'h120);
    tick();
    drive_idle();
    #1;
    check_eq("prio_flush_jal", a_flush_jal, 1'b0);
    check_eq("prio_flush_branch", a_flush_branch, 1'b1);
    // Stalled branch never enters the queue
    drive_br(3'b000, 32'h108, 32'h20);
    stall_in = 1'b1;
    tick();
    drive_idle();
    tick();
    alu_zero = 1'b1;
    #1;
    check_eq("stall_fetch", a_ctrl_fetch, 1'b0);
    tick();
    #1;
    check_eq("stall_branch_cnt", a_branch_cnt, 4'd1);

    // Reset with a full queue wins over the pending resolution
    drive_br(3'b000, 32'h108, 32'h20);
    tick();
    drive_br(3'b000, 32'h10C, 32'h20);
    tick();
    drive_idle(); reset = 1'b1;
    tick();
    reset = 1'b0; alu_zero = 1'b1;
    #1;
    check_eq("rstq_fetch", a_ctrl_fetch, 1'b0);
    check_eq("rstq_new_pc", a_new_pc, 32'h0);
    check_eq("rstq_branch_cnt", a_branch_cnt, 4'h0);
    check_eq("rstq_misp_cnt", a_mispredict_cnt, 4'h0);
    check_eq("rstq_flush_branch", a_flush_branch, 1'b0);
    check_eq("rstq_flush_jal", a_flush_jal, 1'b0);
    tick();
    #1;
    check_eq("rstq_fetch_next", a_ctrl_fetch, 1'b0);

    // Counter saturation
    do_reset();
    for (int k = 0; k < 15; k++) begin
      run_branch(3'b000, 32'h108, 32'h20, 1'b1, 1'b0, cf, npc, fb);
    end
    check_eq("sat_pre_misp", a_mispredict_cnt, 4'hF);
    for (int k = 0; k < 2; k++) begin
      run_branch(3'b000, 32'h108, 32'h20, 1'b1, 1'b0, cf, npc, fb);
    end
    check_eq("sat_last_fetch", cf, 1'b1);
    check_eq("sat_misp_cnt", a_mispredict_cnt, 4'hF);
    check_eq("sat_branch_cnt", a_branch_cnt, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
